// File: rtl/mn_symbol_packer.sv
// mn_symbol_packer
//   Samples the 2-bit symbol {m,n} on cycles with en=1. Four symbols are packed
//   MSB-first into a byte. Each byte is pushed into a first-word-fall-through
//   FIFO that sits behind a valid/ready port. The block also keeps a saturating
//   count of 2'b11 symbols.
// Ports
//   clk, rst_b          rising-edge clock, asynchronous active-low reset
//   m, n, en            symbol bits and sample enable
//   clr                 synchronous clear of all state; overrides en/push/pop
//   out_data/out_valid  head-of-FIFO byte and non-empty flag
//   out_ready           consumer accepts out_data (pop = out_valid & out_ready)
//   level               FIFO occupancy, 0..DEPTH
//   ovf                 sticky flag: a completed byte was dropped on a full FIFO
//   cnt11               saturating count of sampled 2'b11 symbols
module mn_symbol_packer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   m,
  input  logic                   n,
  input  logic                   en,
  input  logic                   clr,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic [CNT_W-1:0]       cnt11
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {P0, P1, P2, P3} slot_t;
  slot_t state, state_nxt;

  logic [1:0]    sym;
  logic [5:0]    sh;        // the first three symbols of the byte, byte bits [7:2]
  logic [7:0]    pk_byte;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, full, push_ok;

  assign sym     = {m, n};
  assign pk_byte = {sh, sym};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)   state <= P0;
    else if (clr) state <= P0;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    if (en) begin
      case (state)
        P0: state_nxt = P1;
        P1: state_nxt = P2;
        P2: state_nxt = P3;
        P3: begin
          state_nxt = P0;
          push      = 1'b1;
        end
        default: state_nxt = P0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)   sh <= '0;
    else if (clr) sh <= '0;
    else if (en) begin
      case (state)
        P0:      sh[5:4] <= sym;
        P1:      sh[3:2] <= sym;
        P2:      sh[1:0] <= sym;
        default: ;
      endcase
    end
  end

  assign out_valid = (level != '0);
  assign full      = (level == LVL_FULL);
  assign pop       = out_valid & out_ready;
  // When the FIFO is full, a pop at the same edge frees the slot the push needs.
  assign push_ok   = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_ptr] <= pk_byte;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                                     cnt11 <= '0;
    else if (clr)                                   cnt11 <= '0;
    else if (en && sym == 2'b11 && cnt11 != '1)     cnt11 <= cnt11 + 1'b1;
  end

  // Forcing out_data to 0 when the FIFO is empty hides stale RAM contents.
  assign out_data = out_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_mn_symbol_packer.sv
module tb_mn_symbol_packer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic m = 1'b0, n = 1'b0, en = 1'b0, clr = 1'b0, out_ready = 1'b0;
  logic [7:0] out_data, out_data4;
  logic       out_valid, out_valid4, ovf, ovf4;
  logic [2:0] level, level4;
  logic [7:0] cnt11;
  logic [3:0] cnt11_4;

  mn_symbol_packer #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst_b(rst_b), .m(m), .n(n), .en(en), .clr(clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .ovf(ovf), .cnt11(cnt11));

  // Second instance with a narrow counter, used for the saturation check.
  mn_symbol_packer #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .rst_b(rst_b), .m(m), .n(n), .en(en), .clr(clr),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .level(level4), .ovf(ovf4), .cnt11(cnt11_4));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Reference model: completed bytes in a queue, partial byte as a list of symbols.
  logic [7:0] q[$];
  logic [1:0] syms[$];
  bit         movf;
  int         c8, c4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete(); syms.delete(); movf = 0; c8 = 0; c4 = 0;
  endtask

  task automatic model_edge();
    logic [1:0] s;
    logic [7:0] b;
    if (clr) model_reset();
    else begin
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (en) begin
        s = {m, n};
        syms.push_back(s);
        if (s == 2'b11) begin
          if (c8 < 255) c8++;
          if (c4 < 15)  c4++;
        end
        if (syms.size() == 4) begin
          b = {syms[0], syms[1], syms[2], syms[3]};
          syms.delete();
          if (q.size() < DEPTH) q.push_back(b);
          else movf = 1;
        end
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ".data"},  32'(out_data),  (q.size() > 0) ? 32'(q[0]) : 32'h0);
    chk({tag, ".level"}, 32'(level),     32'(q.size()));
    chk({tag, ".ovf"},   32'(ovf),       32'(movf));
    chk({tag, ".cnt11"}, 32'(cnt11),     32'(c8));
    chk({tag, ".cnt11_w4"}, 32'(cnt11_4), 32'(c4));
  endtask

  task automatic step(input string tag, input logic [1:0] s, input bit e, input bit c, input bit r);
    {m, n} = s; en = e; clr = c; out_ready = r;
    @(posedge clk);
    model_edge();
    #1;
    cmp_model(tag);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic async_reset(input string tag);
    #2 rst_b = 1'b0;
    model_reset();
    #1;
    chk({tag, ".rst_valid"}, 32'(out_valid), 32'h0);
    chk({tag, ".rst_data"},  32'(out_data),  32'h0);
    chk({tag, ".rst_level"}, 32'(level),     32'h0);
    chk({tag, ".rst_ovf"},   32'(ovf),       32'h0);
    chk({tag, ".rst_cnt"},   32'(cnt11),     32'h0);
    #1 rst_b = 1'b1;
  endtask

  typedef struct {
    logic [1:0] s;
    bit         e;
    bit         r;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [2:0] exp_level;
    logic [7:0] exp_cnt;
  } vec_t;

  initial begin
    vec_t tbl[6];
    tbl[0] = '{2'b11, 1, 1, 1'b0, 8'h00, 3'd0, 8'd1};
    tbl[1] = '{2'b01, 1, 1, 1'b0, 8'h00, 3'd0, 8'd1};
    tbl[2] = '{2'b10, 1, 1, 1'b0, 8'h00, 3'd0, 8'd1};
    tbl[3] = '{2'b00, 1, 1, 1'b1, 8'hD8, 3'd1, 8'd1};
    tbl[4] = '{2'b11, 0, 1, 1'b0, 8'h00, 3'd0, 8'd1};
    tbl[5] = '{2'b11, 0, 1, 1'b0, 8'h00, 3'd0, 8'd1};

    model_reset();
    #1;
    chk("reset.valid", 32'(out_valid), 32'h0);
    chk("reset.data",  32'(out_data),  32'h0);
    chk("reset.level", 32'(level),     32'h0);
    chk("reset.ovf",   32'(ovf),       32'h0);
    chk("reset.cnt11", 32'(cnt11),     32'h0);
    #13 rst_b = 1'b1;

    // T2: table-driven pack of 11,01,10,00 -> 8'hD8, valid for one cycle
    foreach (tbl[i]) begin
      step("t2", tbl[i].s, tbl[i].e, 1'b0, tbl[i].r);
      chk($sformatf("t2[%0d].valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("t2[%0d].data", i),  32'(out_data),  32'(tbl[i].exp_data));
      chk($sformatf("t2[%0d].level", i), 32'(level),     32'(tbl[i].exp_level));
      chk($sformatf("t2[%0d].cnt11", i), 32'(cnt11),     32'(tbl[i].exp_cnt));
    end

    // T1: reset after two symbols, then a fresh byte
    step("t1", 2'b10, 1, 0, 0);
    step("t1", 2'b10, 1, 0, 0);
    async_reset("t1");
    step("t1", 2'b00, 1, 0, 0);
    step("t1", 2'b01, 1, 0, 0);
    step("t1", 2'b10, 1, 0, 0);
    step("t1", 2'b11, 1, 0, 0);
    chk("t1.byte", 32'(out_data), 32'h1B);

    // T3: overflow with out_ready=0, then drain
    step("t3clr", 2'b00, 0, 1, 0);
    for (int i = 0; i < 20; i++) step("t3", 2'b01, 1, 0, 0);
    chk("t3.level_full", 32'(level), 32'd4);
    chk("t3.ovf_set",    32'(ovf),   32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("t3.head", 32'(out_data), 32'h55);
      step("t3drain", 2'b00, 0, 0, 1);
    end
    chk("t3.empty", 32'(out_valid), 32'h0);
    chk("t3.ovf_sticky", 32'(ovf), 32'h1);

    // T4: full FIFO, pop at the edge that completes the next byte
    step("t4clr", 2'b00, 0, 1, 0);
    for (int i = 0; i < 16; i++) step("t4", 2'(i), 1, 0, 0);
    for (int i = 0; i < 3; i++)  step("t4", 2'b11, 1, 0, 0);
    step("t4pop", 2'b10, 1, 0, 1);
    chk("t4.level", 32'(level), 32'd4);
    chk("t4.ovf",   32'(ovf),   32'h0);
    for (int i = 0; i < 5; i++) step("t4drain", 2'b00, 0, 0, 1);

    // T5: clr discards its own sample and the partial byte; en gaps hold state
    step("t5", 2'b11, 1, 0, 0);
    step("t5", 2'b10, 1, 0, 0);
    step("t5clr", 2'b11, 1, 1, 0);
    for (int i = 0; i < 3; i++) step("t5gap", 2'b11, 0, 0, 0);
    step("t5", 2'b00, 1, 0, 0);
    step("t5", 2'b00, 1, 0, 0);
    step("t5", 2'b00, 1, 0, 0);
    step("t5", 2'b11, 1, 0, 0);
    chk("t5.data",  32'(out_data), 32'h03);
    chk("t5.level", 32'(level),    32'd1);
    chk("t5.cnt11", 32'(cnt11),    32'd1);

    // T6: counter saturation on the 4-bit instance
    step("t6clr", 2'b00, 0, 1, 1);
    for (int i = 0; i < 20; i++) step("t6", 2'b11, 1, 0, 1);
    chk("t6.cnt_w4", 32'(cnt11_4), 32'd15);
    chk("t6.cnt_w8", 32'(cnt11),   32'd20);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step("rnd", 2'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 149) == 0) async_reset("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
